// File: rtl/mmu_inst_port_pkg.sv
// mmu_inst_port_pkg: shared widths and sizing helpers for the instruction fetch port
package mmu_inst_port_pkg;
  localparam int FETCH_DEPTH = 4;
  localparam int INST_W = 32;
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/mmu_inst_port_addr_fifo.sv
// addr_fifo: synchronous FIFO of issued read addresses with occupancy count
module addr_fifo
  import mmu_inst_port_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH,
  parameter int AW = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push_i,
  input  logic [AW-1:0]           push_data_i,
  input  logic                    pop_i,
  output logic [AW-1:0]           head_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [cnt_w(DEPTH)-1:0] count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  logic [AW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= push_data_i;
  end
  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
endmodule

// File: rtl/mmu_inst_port.sv
// mmu_inst_port: in-order instruction fetch port with flush-based discard of stale reads
module mmu_inst_port
  import mmu_inst_port_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH,
  parameter int AW = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              INST_RDEN,
  input  logic [AW-1:0]     INST_RIADDR,
  output logic [AW-1:0]     INST_ROADDR,
  output logic              INST_RVALID,
  output logic [INST_W-1:0] INST_RDATA,
  output logic              MEM_WAIT,
  input  logic              FLUSH,
  output logic              BUS_ARVALID,
  output logic [AW-1:0]     BUS_ARADDR,
  input  logic              BUS_ARREADY,
  input  logic              BUS_RVALID,
  input  logic [INST_W-1:0] BUS_RDATA
);
  localparam int CW = cnt_w(DEPTH);
  logic              ar_valid_q, ar_valid_d;
  logic [AW-1:0]     ar_addr_q, ar_addr_d;
  logic [CW-1:0]     drop_q, drop_d;
  logic              rvalid_q, rvalid_d;
  logic [AW-1:0]     roaddr_q, roaddr_d;
  logic [INST_W-1:0] rdata_q, rdata_d;
  logic [CW-1:0]     count, occ_pop, occ_next;
  logic [AW-1:0]     head;
  logic              push, pop, empty, full, accept, drop_now;
  addr_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk(CLK), .rst(RST), .push_i(push), .push_data_i(ar_addr_q), .pop_i(pop),
    .head_o(head), .full_o(full), .empty_o(empty), .count_o(count)
  );
  always_comb begin
    pop        = BUS_RVALID & ~empty;
    push       = ar_valid_q & BUS_ARREADY;
    occ_pop    = count - CW'(pop);
    MEM_WAIT   = FLUSH | (ar_valid_q & ~BUS_ARREADY) | (occ_pop + CW'(ar_valid_q) >= CW'(DEPTH));
    accept     = INST_RDEN & ~MEM_WAIT;
    ar_valid_d = accept | (ar_valid_q & ~BUS_ARREADY);
    ar_addr_d  = accept ? INST_RIADDR : ar_addr_q;
    drop_now   = pop & (drop_q != '0);
    occ_next   = occ_pop + CW'(push);
    // a flush marks everything still in flight, including an unsent AR, as stale
    drop_d     = FLUSH ? occ_next + CW'(ar_valid_d) : drop_q - CW'(drop_now);
    rvalid_d   = pop & ~drop_now & ~FLUSH;
    roaddr_d   = rvalid_d ? head : roaddr_q;
    rdata_d    = rvalid_d ? BUS_RDATA : rdata_q;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ar_valid_q <= 1'b0;
      ar_addr_q  <= '0;
      drop_q     <= '0;
      rvalid_q   <= 1'b0;
      roaddr_q   <= '0;
      rdata_q    <= '0;
    end else begin
      ar_valid_q <= ar_valid_d;
      ar_addr_q  <= ar_addr_d;
      drop_q     <= drop_d;
      rvalid_q   <= rvalid_d;
      roaddr_q   <= roaddr_d;
      rdata_q    <= rdata_d;
    end
  end
  assign BUS_ARVALID = ar_valid_q;
  assign BUS_ARADDR  = ar_addr_q;
  assign INST_RVALID = rvalid_q;
  assign INST_ROADDR = roaddr_q;
  assign INST_RDATA  = rdata_q;
  a_no_orphan_resp: assert property (@(posedge CLK) disable iff (RST) !(BUS_RVALID && empty));
  a_no_overflow: assert property (@(posedge CLK) disable iff (RST) !(push && full && !pop));
endmodule

// File: tb/tb_mmu_inst_port.sv
// tb_mmu_inst_port: randomized and directed checks against a queue-based fetch model
module tb_mmu_inst_port;
  localparam int DEPTH = 4;
  logic        CLK = 0, RST = 1;
  logic        INST_RDEN = 0, FLUSH = 0, BUS_ARREADY = 0, BUS_RVALID = 0;
  logic [31:0] INST_RIADDR = 0, BUS_RDATA = 0;
  logic [31:0] INST_ROADDR, INST_RDATA, BUS_ARADDR;
  logic        INST_RVALID, MEM_WAIT, BUS_ARVALID;
  int n_cmp = 0, n_bad = 0;
  typedef struct packed { logic [31:0] a; bit stale; } ent_t;
  ent_t q[$];
  bit          m_arv = 0, m_ars = 0, m_rv = 0;
  logic [31:0] m_ara = 0, m_ra = 0, m_rd = 0;
  int pr[4] = '{80, 50, 95, 30};
  int pa[4] = '{70, 30, 90, 50};
  int pv[4] = '{50, 20, 80, 60};
  int pf[4] = '{5, 2, 10, 20};

  mmu_inst_port #(.DEPTH(DEPTH), .AW(32)) dut (
    .CLK(CLK), .RST(RST), .INST_RDEN(INST_RDEN), .INST_RIADDR(INST_RIADDR),
    .INST_ROADDR(INST_ROADDR), .INST_RVALID(INST_RVALID), .INST_RDATA(INST_RDATA),
    .MEM_WAIT(MEM_WAIT), .FLUSH(FLUSH), .BUS_ARVALID(BUS_ARVALID), .BUS_ARADDR(BUS_ARADDR),
    .BUS_ARREADY(BUS_ARREADY), .BUS_RVALID(BUS_RVALID), .BUS_RDATA(BUS_RDATA)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_zero();
    check("rst_rvalid", INST_RVALID, 0);
    check("rst_roaddr", INST_ROADDR, 0);
    check("rst_rdata", INST_RDATA, 0);
    check("rst_arvalid", BUS_ARVALID, 0);
    check("rst_araddr", BUS_ARADDR, 0);
    check("rst_memwait", MEM_WAIT, 0);
  endtask

  // one clock: drive at negedge, check registered outputs and MEM_WAIT, advance model
  task automatic step(input bit rden, input logic [31:0] a, input bit fl, input bit ar,
                      input bit rv, input logic [31:0] d);
    ent_t e;
    bit rvx, mw, acc, hs;
    @(negedge CLK);
    rvx = rv && q.size() > 0;
    INST_RDEN = rden; INST_RIADDR = a; FLUSH = fl;
    BUS_ARREADY = ar; BUS_RVALID = rvx; BUS_RDATA = d;
    #1;
    check("rvalid", INST_RVALID, m_rv);
    if (m_rv) begin
      check("roaddr", INST_ROADDR, m_ra);
      check("rdata", INST_RDATA, m_rd);
    end
    check("arvalid", BUS_ARVALID, m_arv);
    if (m_arv) check("araddr", BUS_ARADDR, m_ara);
    mw = fl || (m_arv && !ar) || (q.size() - int'(rvx) + int'(m_arv) >= DEPTH);
    check("mem_wait", MEM_WAIT, mw);
    hs = m_arv && ar;
    acc = rden && !mw;
    m_rv = 0;
    if (rvx) begin
      e = q.pop_front();
      m_rv = !e.stale && !fl;
      m_ra = e.a;
      m_rd = d;
    end
    if (hs) begin
      e.a = m_ara; e.stale = m_ars;
      q.push_back(e);
    end
    if (acc) begin
      m_arv = 1; m_ara = a; m_ars = 0;
    end else if (hs) m_arv = 0;
    if (fl) begin
      foreach (q[i]) q[i].stale = 1;
      m_ars = 1;
    end
  endtask

  task automatic reset_mid();
    @(negedge CLK);
    #2;
    INST_RDEN = 0; FLUSH = 0; BUS_RVALID = 0; BUS_ARREADY = 0;
    RST = 1;
    #1;
    check_zero();
    @(negedge CLK);
    RST = 0;
    q.delete();
    m_arv = 0; m_ars = 0; m_rv = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (q.size() > 0 || m_arv); i++) step(0, 0, 0, 1, 1, $urandom);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    check_zero();
    RST = 0;
    // basic in-order fetch
    step(1, 'h0, 0, 1, 0, 0);
    step(1, 'h4, 0, 1, 0, 0);
    step(1, 'h8, 0, 1, 0, 0);
    step(0, 0, 0, 1, 1, 'h1111_0000);
    step(0, 0, 0, 1, 1, 'h2222_0004);
    step(0, 0, 0, 1, 1, 'h3333_0008);
    drain();
    // AR stall holds address and asserts MEM_WAIT
    step(1, 'h10, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 'h14, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    drain();
    // fill to DEPTH without responses
    for (int i = 0; i < 8; i++) step(1, 32'h200 + 32'(i * 4), 0, 1, 0, 0);
    step(1, 'h300, 0, 1, 1, 'hABCD_0001);
    step(1, 'h304, 0, 1, 0, 0);
    step(1, 'h308, 0, 1, 0, 0);
    drain();
    // flush with three reads outstanding
    step(1, 'h20, 0, 1, 0, 0);
    step(1, 'h24, 0, 1, 0, 0);
    step(1, 'h28, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1, $urandom);
    step(1, 'h100, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 1, 'hCAFE_0100);
    drain();
    // flush coinciding with a response and a stalled AR
    step(1, 'h40, 0, 1, 0, 0);
    step(1, 'h44, 0, 1, 0, 0);
    step(0, 0, 1, 0, 1, 'hDEAD_0040);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 1, 'hDEAD_0044);
    step(1, 'h48, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 1, 'hBEEF_0048);
    drain();
    // reset with reads outstanding, then resume from 0
    step(1, 'h50, 0, 1, 0, 0);
    step(1, 'h54, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    reset_mid();
    step(1, 'h0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 1, 'h0000_1234);
    drain();
    // randomized phases with varied pressure
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 300; c++) begin
        if ($urandom_range(0, 249) == 0) reset_mid();
        else step($urandom_range(0, 99) < pr[p], {20'h0, 10'($urandom_range(0, 1023)), 2'b00},
                  $urandom_range(0, 99) < pf[p], $urandom_range(0, 99) < pa[p],
                  $urandom_range(0, 99) < pv[p], $urandom);
      end
      drain();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
